switch_debounce_sync: RTL and testbench
=======================================

Name: switch_debounce_sync

Overview:
- Upstream input stage for the 8-bit priority encoder / 7-segment decoder.
- Takes 8 raw, asynchronous, bouncing switch inputs and synchronises each bit with a 2-flop synchroniser.
- Debounces each bit independently and presents a clean, registered 8-bit data word that drives the encoder's data input directly.
- Also provides a change strobe, a hold (freeze) control and a settled indicator.

Parameters:
- WIDTH, 8, number of input channels; equals the encoder data width.
- CNT_W, 16, width of each per-bit debounce counter.
- DEBOUNCE_CYCLES, 10000, consecutive synchronised cycles a new level must persist before it is accepted. Legal range 1 to 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active low.
- raw  input  WIDTH  asynchronous switch inputs.
- hold  input  1  when 1, freezes data; debouncing continues.
- data  output  WIDTH  debounced, registered word to the encoder.
- changed  output  1  one-cycle pulse on the edge where data changes.
- settled  output  1  1 when no bit has a pending, different synchronised level.

Behaviour:
- Clocking: one clock. Reset is synchronous and active-low: sampled on the clk rising edge when rst_n=0.
- Reset values: sync stages 0, counters 0, data 0, changed 0, settled 1.
- Reset mid-operation discards all pending counts. After rst_n rises, a raw input held at 1 produces data=1 on that bit after the full latency.
- Synchroniser per bit: s1 <= raw, s2 <= s1. Only s2 is used downstream.
- Per-bit debounce, evaluated every edge when not in reset:
  - s2 == data[i]: cnt[i] <= 0.
  - s2 != data[i], cnt[i] < D-1: cnt[i] <= cnt[i]+1.
  - s2 != data[i], cnt[i] == D-1, hold=0: data[i] <= s2; cnt[i] <= 0.
  - s2 != data[i], cnt[i] == D-1, hold=1: cnt[i] stays at D-1 (saturates); data[i] unchanged.
- Latency:
  - Let N be the first edge at which raw[i] is sampled at the new level into s1, with the level held steady thereafter.
  - data[i] updates at edge N+1+D, i.e. D+1 cycles after N.
  - D=1 gives update at N+2.
- Glitch rejection: a level change lasting fewer than D cycles at s2 clears the counter when s2 returns. data is unaffected and changed stays 0.
- Bits are fully independent. Several bits may update on the same edge; this produces a single changed pulse.
- changed: registered, high for exactly the cycle following any edge at which data was written with a different value. Never high while hold=1.
- Hold release: a bit whose counter is saturated at D-1 updates on the first edge with hold=0 where s2 still differs. If s2 has reverted, the counter clears and no update occurs.
- settled = 1 when every cnt[i] == 0 and every s2[i] == data[i]. Combinational from registers; no combinational path from raw.
- No arithmetic overflow: counters never exceed D-1.

Decomposition:
- Shared package holds:
  - default constants: WIDTH_DEF=8, CNT_W_DEF=16, DEBOUNCE_DEF=10000;
  - SIM_DEBOUNCE=4 for benches.
- Sub-module debounce_bit (CNT_W, DEBOUNCE_CYCLES):
  - one synchroniser, one counter and one data flop;
  - ports clk, rst_n, raw, hold, q, pending.
- Top instantiates WIDTH copies in a generate loop and adds:
  - the changed register;
  - the settled reduction.

Test Plan (D=4, CNT_W=4):
- Reset: hold raw=8'hFF with rst_n=0 for 3 cycles -> data=8'h00, changed=0, settled=1 during reset. After release, data=8'hFF exactly 5 cycles after the first post-reset sampling edge, with one changed pulse.
- Latency: raw 8'h00->8'h20 steady -> data=8'h20 at edge N+5, changed=1 for one cycle, settled=0 from N+1 until N+5.
- Glitch: raw bit 3 high for 3 cycles then low -> data stays 8'h00, changed never asserts, settled returns to 1.
- Bounce: raw bit 7 toggles every 2 cycles for 10 cycles, then stays 1 -> single data change to 8'h80, D+1 cycles after the last toggle is sampled; one changed pulse.
- Hold: hold=1, raw 8'h00->8'h05 for 20 cycles -> data=8'h00, changed=0. Drop hold -> data=8'h05 on the next edge, one changed pulse.
- Simultaneous and reset mid-count:
  - raw 8'h00->8'h81 on one edge -> both bits update together, single changed pulse.
  - Repeat with rst_n=0 asserted for 1 cycle at count 2 -> data=8'h00, and the update lands 5 cycles after the first sampling edge following reset release.

Source files
------------

// File: rtl/switch_debounce_sync_pkg.sv
// Shared constants and the per-bit debounce decision for the switch input stage.
// The decision helper keeps the counter/data update rule in one place.
package switch_debounce_sync_pkg;

   localparam int WIDTH_DEF    = 8;
   localparam int CNT_W_DEF    = 16;
   localparam int DEBOUNCE_DEF = 10000;
   localparam int SIM_DEBOUNCE = 4;

   typedef enum logic [1:0] {
      ACT_CLR  = 2'd0,
      ACT_INC  = 2'd1,
      ACT_SAT  = 2'd2,
      ACT_UPD  = 2'd3
   } db_act_e;

   // A differing level that has lasted long enough either updates or, under hold, parks.
   function automatic db_act_e db_action(input logic differ, input logic at_max,
                                         input logic hold);
      db_act_e act;
      act = ACT_CLR;
      if (differ) begin
         if (!at_max)    act = ACT_INC;
         else if (hold)  act = ACT_SAT;
         else            act = ACT_UPD;
      end
      return act;
   endfunction

endpackage

// File: rtl/switch_debounce_sync_debounce_bit.sv
// One switch channel: 2-flop synchroniser, debounce counter and the accepted level.
// pending flags a channel that is not yet at rest.
module debounce_bit
   import switch_debounce_sync_pkg::*;
#(
   parameter int CNT_W           = CNT_W_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   input  logic hold,
   output logic q,
   output logic pending
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
   db_act_e          act;

   always_comb begin
      s1_d  = raw;
      s2_d  = s1_q;
      cnt_d = cnt_q;
      q_d   = q_q;
      act   = db_action(s2_q != q_q, cnt_q == CNT_MAX, hold);
      case (act)
         ACT_CLR: cnt_d = '0;
         ACT_INC: cnt_d = cnt_q + CNT_W'(1);
         ACT_SAT: cnt_d = cnt_q;
         ACT_UPD: begin
            q_d   = s2_q;
            cnt_d = '0;
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         cnt_q <= '0;
         q_q   <= 1'b0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         cnt_q <= cnt_d;
         q_q   <= q_d;
      end
   end

   assign q       = q_q;
   assign pending = (cnt_q != '0) || (s2_q != q_q);

endmodule

// File: rtl/switch_debounce_sync.sv
// Synchronises and debounces WIDTH switch inputs into a clean word for the encoder,
// with a one-cycle change strobe and a settled indicator.
module switch_debounce_sync
   import switch_debounce_sync_pkg::*;
#(
   parameter int WIDTH           = WIDTH_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw,
   input  logic             hold,
   output logic [WIDTH-1:0] data,
   output logic             changed,
   output logic             settled
);

   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] data_prev_q, data_prev_d;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      debounce_bit #(
         .CNT_W           (CNT_W),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw     (raw[g]),
         .hold    (hold),
         .q       (data[g]),
         .pending (pend[g])
      );
   end

   always_comb begin
      data_prev_d = data;
   end

   // Both sides of the compare are flops, so the strobe is glitch-free and lasts
   // exactly the cycle after any edge that wrote a new word.
   always_ff @(posedge clk) begin
      if (!rst_n) data_prev_q <= '0;
      else        data_prev_q <= data_prev_d;
   end

   assign changed = |(data ^ data_prev_q);
   assign settled = ~|pend;

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Directed bench for switch_debounce_sync with D=4, CNT_W=4.
module tb_switch_debounce_sync;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] raw;
   logic       hold;
   logic [7:0] data;
   logic       changed;
   logic       settled;

   int total = 0;
   int bad   = 0;

   switch_debounce_sync #(
      .WIDTH           (8),
      .CNT_W           (4),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (raw),
      .hold    (hold),
      .data    (data),
      .changed (changed),
      .settled (settled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k = 0 is the first edge sampling the new level; update expected at k = 5.
   task automatic run_lat(input string tag, input logic [7:0] v, input logic [7:0] old);
      raw = v;
      for (int k = 0; k <= 6; k++) begin
         tick();
         chk({tag, "_data"}, data, (k >= 5) ? v : old);
         chk({tag, "_chg"}, changed, (k == 5) ? 1 : 0);
         chk({tag, "_stl"}, settled, (k >= 1 && k <= 4) ? 0 : 1);
      end
   endtask

   task automatic settle(input logic [7:0] v);
      raw = v;
      repeat (10) tick();
      chk("settle", data, v);
      chk("settle_stl", settled, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      raw   = 8'hFF;
      hold  = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_data", data, 8'h00);
         chk("rst_chg", changed, 0);
         chk("rst_stl", settled, 1);
      end
      rst_n = 1'b1;
      run_lat("rstrel", 8'hFF, 8'h00);

      settle(8'h00);
      run_lat("lat", 8'h20, 8'h00);
      settle(8'h00);

      // glitch: three high samples are one short of acceptance
      raw = 8'h08;
      repeat (3) tick();
      raw = 8'h00;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("glitch_data", data, 8'h00);
         chk("glitch_chg", changed, 0);
      end
      chk("glitch_stl", settled, 1);

      // bounce: bit 7 toggles every 2 cycles for 10 cycles, then stays high
      for (int c = 0; c <= 16; c++) begin
         raw = (c >= 10 || ((c / 2) % 2 == 0)) ? 8'h80 : 8'h00;
         tick();
         chk("bounce_data", data, (c >= 13) ? 8'h80 : 8'h00);
         chk("bounce_chg", changed, (c == 13) ? 1 : 0);
      end
      settle(8'h00);

      // hold freezes the word, release lands on the next edge
      hold = 1'b1;
      raw  = 8'h05;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold_data", data, 8'h00);
         chk("hold_chg", changed, 0);
      end
      hold = 1'b0;
      tick();
      chk("hrel_data", data, 8'h05);
      chk("hrel_chg", changed, 1);
      tick();
      chk("hrel_chg2", changed, 0);
      settle(8'h00);

      // hold with the level reverting before release: no update
      hold = 1'b1;
      raw  = 8'h02;
      repeat (10) tick();
      raw = 8'h00;
      repeat (5) tick();
      hold = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hrev_data", data, 8'h00);
         chk("hrev_chg", changed, 0);
      end

      run_lat("simul", 8'h81, 8'h00);
      settle(8'h00);

      // reset while the counters sit at 2
      raw = 8'h81;
      for (int k = 0; k <= 3; k++) begin
         tick();
         chk("mid_data", data, 8'h00);
      end
      rst_n = 1'b0;
      tick();
      chk("mid_rst_data", data, 8'h00);
      chk("mid_rst_chg", changed, 0);
      chk("mid_rst_stl", settled, 1);
      rst_n = 1'b1;
      run_lat("midrel", 8'h81, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
